// File: rtl/typhoon_pkg.sv
// Shared constants and types for the tile shader / writeback pipeline.
package typhoon_pkg;
  localparam int TILE_DIM = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 20;
  localparam int CNT_W    = $clog2(TILE_DIM);

  typedef logic [15:0] pixel_t;
  typedef pixel_t tile_t [TILE_DIM][TILE_DIM];

  typedef enum logic [1:0] {WB_IDLE, WB_SETUP, WB_WRITE, WB_DONE} wb_state_t;

  // True when the tile pixel (c, r) lands inside the visible screen.
  function automatic logic in_screen(input logic [9:0] x0, input logic [9:0] y0,
                                     input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] r);
    logic [10:0] px, py;
    px = {1'b0, x0} + 11'(c);
    py = {1'b0, y0} + 11'(r);
    return (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
  endfunction
endpackage

// File: rtl/tile_writeback_if.sv
// Framebuffer write port: valid/ready handshake carrying one pixel per beat.
interface tile_writeback_if;
  import typhoon_pkg::*;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  pixel_t            mem_data;
  logic              mem_ready;

  modport master (output mem_we, mem_addr, mem_data, input mem_ready);
  modport slave  (input mem_we, mem_addr, mem_data, output mem_ready);
endinterface

// File: rtl/tile_scan_counter.sv
// Row-major tile walker: col/row counters plus a running row address so no
// per-pixel multiply is needed.
module tile_scan_counter
  import typhoon_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  output logic [CNT_W-1:0]  col,
  output logic [CNT_W-1:0]  row,
  output logic [ADDR_W-1:0] row_addr,
  output logic              last
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(TILE_DIM - 1);

  logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_addr_d = row_addr_q;
    if (clear) begin
      col_d      = '0;
      row_d      = '0;
      row_addr_d = base;
    end else if (en) begin
      if (col_q == MAX) begin
        col_d      = '0;
        row_d      = row_q + 1'b1;
        row_addr_d = row_addr_q + ADDR_W'(SCREEN_W);
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      row_addr_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_addr_q <= row_addr_d;
    end
  end

  assign col      = col_q;
  assign row      = row_q;
  assign row_addr = row_addr_q;
  assign last     = (col_q == MAX) && (row_q == MAX);
endmodule

// File: rtl/tile_writeback.sv
// Drains a finished colour tile into the framebuffer and reports buffer ownership.
// Define TILE_WB_CLIP_EN to skip pixels that fall off the right/bottom screen edge.
module tile_writeback
  import typhoon_pkg::*;
(
  input  logic             BOARD_CLK,
  input  logic             RESET_N,
  input  logic             startFlush,
  input  logic             flushTileID,
  input  logic [9:0]       xOffset,
  input  logic [9:0]       yOffset,
  input  tile_t            cBufferTile0,
  input  tile_t            cBufferTile1,
  tile_writeback_if.master mem,
  output logic             busy,
  output logic             doneFlushing,
  output logic [1:0]       tileFree
);
  wb_state_t         state_q, state_d;
  logic              id_q, id_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              clear, advance, clip, last;
  logic [CNT_W-1:0]  col, row;
  logic [ADDR_W-1:0] row_addr, base_addr;
  pixel_t            pixel;

  assign base_addr = ADDR_W'(y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(x_q);

`ifdef TILE_WB_CLIP_EN
  assign clip = !in_screen(x_q, y_q, col, row);
`else
  assign clip = 1'b0;
`endif

  // Clipped pixels step without waiting on the memory.
  assign advance = (state_q == WB_WRITE) && (mem.mem_ready || clip);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    clear   = 1'b0;
    case (state_q)
      WB_IDLE: if (startFlush) begin
        id_d    = flushTileID;
        x_d     = xOffset;
        y_d     = yOffset;
        state_d = WB_SETUP;
      end
      WB_SETUP: begin
        clear   = 1'b1;
        state_d = WB_WRITE;
      end
      WB_WRITE: if (advance && last) state_d = WB_DONE;
      WB_DONE:  state_d = WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= WB_IDLE;
      id_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  tile_scan_counter u_scan (
    .clk      (BOARD_CLK),
    .rst_n    (RESET_N),
    .clear    (clear),
    .en       (advance),
    .base     (base_addr),
    .col      (col),
    .row      (row),
    .row_addr (row_addr),
    .last     (last)
  );

  assign pixel = id_q ? cBufferTile1[col][row] : cBufferTile0[col][row];

  assign mem.mem_we   = (state_q == WB_WRITE) && !clip;
  assign mem.mem_addr = (state_q == WB_WRITE) ? row_addr + ADDR_W'(col) : '0;
  assign mem.mem_data = (state_q == WB_WRITE) ? pixel : '0;

  assign busy         = (state_q != WB_IDLE);
  assign doneFlushing = (state_q == WB_DONE);

  always_comb begin
    tileFree = 2'b11;
    if (state_q == WB_SETUP || state_q == WB_WRITE) tileFree[id_q] = 1'b0;
  end
endmodule
